// File: rtl/segment_source.sv
// rtl/segment_source.sv - waypoint FIFO to collision-detector segment stream; optional result capture under SEG_SOURCE_HIT_EN
module segment_source #(
    parameter int DEPTH   = 8,
    parameter int SPACING = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wp_val,
    output logic       wp_rdy,
    input  logic [7:0] wp_x,
    input  logic [7:0] wp_y,
    input  logic [7:0] wp_z,
    input  logic       wp_last,
    output logic       seg_val,
    output logic [7:0] seg_x1,
    output logic [7:0] seg_y1,
    output logic [7:0] seg_z1,
    output logic [7:0] seg_x2,
    output logic [7:0] seg_y2,
    output logic [7:0] seg_z2,
    output logic [7:0] seg_id,
    input  logic       res_val,
    input  logic [7:0] res_line_id,
    output logic       path_done,
    output logic       hit,
    output logic [7:0] hit_id
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (SPACING > 1) ? $clog2(SPACING) : 1;

    typedef enum logic [1:0] {S_FIRST, S_EMIT, S_GAP} state_t;

    state_t        state, state_nxt;
    logic [24:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          push, pop, first_pop, emit_pop, empty, head_last;
    logic [24:0]   head;
    logic [23:0]   prev;
    logic [7:0]    seg_cnt;
    logic [GW-1:0] gap_cnt;

    assign wp_rdy    = (count != (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign push      = wp_val && wp_rdy;
    assign head      = mem[rd_ptr];
    assign head_last = head[0];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {wp_x, wp_y, wp_z, wp_last};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FIRST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FIRST: if (!empty && !path_done && !head_last) state_nxt = S_EMIT;
            S_EMIT:  if (!empty) state_nxt = head_last ? S_FIRST : ((SPACING > 1) ? S_GAP : S_EMIT);
            S_GAP:   if (gap_cnt == '0) state_nxt = S_EMIT;
            default: state_nxt = S_FIRST;
        endcase
    end

    // A new path is not started in the same cycle path_done is still visible.
    always_comb begin
        first_pop = (state == S_FIRST) && !empty && !path_done;
        emit_pop  = (state == S_EMIT) && !empty;
        pop       = first_pop || emit_pop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_val   <= 1'b0;
            path_done <= 1'b0;
            {seg_x1, seg_y1, seg_z1, seg_x2, seg_y2, seg_z2} <= '0;
            seg_id    <= '0;
            seg_cnt   <= '0;
            prev      <= '0;
            gap_cnt   <= '0;
        end else begin
            seg_val   <= emit_pop;
            path_done <= pop && head_last;
            if (first_pop) begin
                prev    <= head[24:1];
                seg_cnt <= '0;
            end
            if (emit_pop) begin
                {seg_x1, seg_y1, seg_z1} <= prev;
                {seg_x2, seg_y2, seg_z2} <= head[24:1];
                seg_id  <= seg_cnt;
                seg_cnt <= seg_cnt + 8'd1;
                prev    <= head[24:1];
                gap_cnt <= GW'(SPACING - 2);
            end else if (state == S_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

`ifdef SEG_SOURCE_HIT_EN
    // A path start clears the capture and takes priority over a coincident result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit    <= 1'b0;
            hit_id <= '0;
        end else if (first_pop) begin
            hit    <= 1'b0;
            hit_id <= '0;
        end else if (res_val && !hit) begin
            hit    <= 1'b1;
            hit_id <= res_line_id;
        end
    end
`else
    logic unused_res;
    assign unused_res = res_val ^ (^res_line_id);
    assign hit        = 1'b0;
    assign hit_id     = '0;
`endif

endmodule

// File: tb/tb_segment_source.sv
// tb/tb_segment_source.sv - self-checking bench for segment_source with a schedule-based reference model
module tb_segment_source;

    logic       clk, reset, wp_val, wp_last, res_val;
    logic [7:0] wp_x, wp_y, wp_z, res_line_id;

    logic [2:0] rdy_o, sv_o, pd_o, hit_o;
    logic [7:0] x1_o [3], y1_o [3], z1_o [3], x2_o [3], y2_o [3], z2_o [3], id_o [3], hid_o [3];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        segment_source #(.DEPTH(8), .SPACING((g == 0) ? 1 : (g == 1) ? 3 : 20)) dut (
            .clk(clk), .reset(reset),
            .wp_val(wp_val), .wp_rdy(rdy_o[g]),
            .wp_x(wp_x), .wp_y(wp_y), .wp_z(wp_z), .wp_last(wp_last),
            .seg_val(sv_o[g]),
            .seg_x1(x1_o[g]), .seg_y1(y1_o[g]), .seg_z1(z1_o[g]),
            .seg_x2(x2_o[g]), .seg_y2(y2_o[g]), .seg_z2(z2_o[g]),
            .seg_id(id_o[g]),
            .res_val(res_val), .res_line_id(res_line_id),
            .path_done(pd_o[g]), .hit(hit_o[g]), .hit_id(hid_o[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h, want %0h", nm, inst, act, exp);
        end
    endtask

    // Reference model: waypoint queues plus an earliest-next-pop schedule per instance.
    int          spc [3] = '{1, 3, 20};
    logic [24:0] mq [3][256];
    int          qh [3], qt [3], next_ok [3];
    bit          in_path [3];
    logic [23:0] prv [3];
    logic [7:0]  cnt [3];
    bit          e_sv [3], e_pd [3], e_hit [3];
    logic [47:0] e_seg [3];
    logic [7:0]  e_id [3], e_hid [3];
    int          cyc = 0;

    always @(negedge clk) begin
        logic [24:0] e;
        int  sz;
        bit  clr, nsv, npd;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                qh[i] = 0; qt[i] = 0; next_ok[i] = 0; in_path[i] = 0; prv[i] = '0; cnt[i] = '0;
                e_sv[i] = 0; e_pd[i] = 0; e_hit[i] = 0; e_seg[i] = '0; e_id[i] = '0; e_hid[i] = '0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            chk("wp_rdy", i, 64'(rdy_o[i]), 64'((qt[i] - qh[i]) != 8));
            chk("seg_val", i, 64'(sv_o[i]), 64'(e_sv[i]));
            chk("path_done", i, 64'(pd_o[i]), 64'(e_pd[i]));
            chk("seg", i, 64'({x1_o[i], y1_o[i], z1_o[i], x2_o[i], y2_o[i], z2_o[i]}), 64'(e_seg[i]));
            chk("seg_id", i, 64'(id_o[i]), 64'(e_id[i]));
            chk("hit", i, 64'(hit_o[i]), 64'(e_hit[i]));
            chk("hit_id", i, 64'(hid_o[i]), 64'(e_hid[i]));
        end
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                sz = qt[i] - qh[i];
                clr = 0; nsv = 0; npd = 0;
                if (sz > 0 && cyc >= next_ok[i]) begin
                    e = mq[i][qh[i] & 255];
                    qh[i]++;
                    if (!in_path[i]) begin
                        prv[i] = e[24:1]; cnt[i] = 8'd0; clr = 1;
                        if (e[0]) begin npd = 1; next_ok[i] = cyc + 2; end
                        else begin in_path[i] = 1; next_ok[i] = cyc + 1; end
                    end else begin
                        nsv = 1;
                        e_seg[i] = {prv[i], e[24:1]};
                        e_id[i] = cnt[i];
                        cnt[i] = cnt[i] + 8'd1;
                        prv[i] = e[24:1];
                        if (e[0]) begin npd = 1; in_path[i] = 0; next_ok[i] = cyc + 2; end
                        else next_ok[i] = cyc + spc[i];
                    end
                end
`ifdef SEG_SOURCE_HIT_EN
                if (clr) begin e_hit[i] = 0; e_hid[i] = '0; end
                else if (res_val && !e_hit[i]) begin e_hit[i] = 1; e_hid[i] = res_line_id; end
`endif
                if (wp_val && sz != 8) begin
                    mq[i][qt[i] & 255] = {wp_x, wp_y, wp_z, wp_last};
                    qt[i]++;
                end
                e_sv[i] = nsv;
                e_pd[i] = npd;
            end
        end
        cyc++;
    end

    bit          rec_on = 0;
    int          rc = 0;
    int          rec_cyc [$];
    logic [7:0]  rec_id [$];
    always @(negedge clk) begin
        if (rec_on && sv_o[1]) begin
            rec_cyc.push_back(rc);
            rec_id.push_back(id_o[1]);
        end
        rc++;
    end

    task automatic step_wp(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z, input logic l);
        @(posedge clk); #1;
        wp_val = 1'b1; wp_x = x; wp_y = y; wp_z = z; wp_last = l;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            wp_val = 1'b0; wp_last = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0; wp_val = 1'b0; wp_last = 1'b0; wp_x = '0; wp_y = '0; wp_z = '0;
        res_val = 1'b0; res_line_id = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle(2);

        // Three-point path A,B,C pushed in cycles 0..2
        step_wp(8'd1, 8'd2, 8'd3, 1'b0);
        step_wp(8'd4, 8'd5, 8'd6, 1'b0);
        step_wp(8'd7, 8'd8, 8'd9, 1'b1);
        idle(1);
        @(negedge clk);
        chk("abc_sv0", 0, 64'(sv_o[0]), 64'd1);
        chk("abc_id0", 0, 64'(id_o[0]), 64'd0);
        chk("abc_seg0", 0, 64'({x1_o[0], y1_o[0], z1_o[0], x2_o[0], y2_o[0], z2_o[0]}), 64'h010203040506);
        chk("abc_pd_early", 0, 64'(pd_o[0]), 64'd0);
        @(negedge clk);
        chk("abc_sv1", 0, 64'(sv_o[0]), 64'd1);
        chk("abc_id1", 0, 64'(id_o[0]), 64'd1);
        chk("abc_seg1", 0, 64'({x1_o[0], y1_o[0], z1_o[0], x2_o[0], y2_o[0], z2_o[0]}), 64'h040506070809);
        chk("abc_pd", 0, 64'(pd_o[0]), 64'd1);
        idle(60);

        // Single-waypoint path, then a two-point path
        step_wp(8'd10, 8'd10, 8'd10, 1'b1);
        idle(1);
        @(negedge clk);
        chk("single_pd_pop", 0, 64'(pd_o[0]), 64'd0);
        @(negedge clk);
        chk("single_pd", 0, 64'(pd_o[0]), 64'd1);
        chk("single_sv", 0, 64'(sv_o[0]), 64'd0);
        step_wp(8'd20, 8'd21, 8'd22, 1'b0);
        step_wp(8'd30, 8'd31, 8'd32, 1'b1);
        idle(1);
        @(negedge clk);
        @(negedge clk);
        chk("after_single_sv", 0, 64'(sv_o[0]), 64'd1);
        chk("after_single_id", 0, 64'(id_o[0]), 64'd0);
        chk("after_single_seg", 0, 64'({x1_o[0], y1_o[0], z1_o[0], x2_o[0], y2_o[0], z2_o[0]}), 64'h1415161e1f20);
        idle(60);

        // Five-point path back-to-back, observed on the SPACING=3 instance
        rec_on = 1'b1;
        for (int k = 0; k < 5; k++)
            step_wp(8'(50 + k), 8'(60 + k), 8'(70 + k), (k == 4));
        idle(25);
        rec_on = 1'b0;
        chk("spacing_pulses", 1, 64'(rec_cyc.size()), 64'd4);
        for (int k = 0; k < rec_cyc.size(); k++) begin
            chk("spacing_id", 1, 64'(rec_id[k]), 64'(k));
            if (k > 0) chk("spacing_gap", 1, 64'(rec_cyc[k] - rec_cyc[k-1]), 64'd3);
        end
        idle(100);

        // Fill the SPACING=20 instance while it sits in its gap
        for (int k = 0; k < 12; k++) begin
            step_wp(8'(100 + k), 8'(k), 8'(k), 1'b0);
            @(negedge clk);
            if (k == 9)  chk("fill_rdy_high", 2, 64'(rdy_o[2]), 64'd1);
            if (k == 10) chk("fill_rdy_low", 2, 64'(rdy_o[2]), 64'd0);
            if (k == 11) chk("fill_rdy_held", 2, 64'(rdy_o[2]), 64'd0);
        end

        // Reset mid-path
        @(posedge clk); #1;
        wp_val = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("rst_sv", 0, 64'(sv_o[0]), 64'd0);
        chk("rst_seg", 0, 64'({x1_o[0], y1_o[0], z1_o[0], x2_o[0], y2_o[0], z2_o[0], id_o[0]}), 64'd0);
        chk("rst_pd", 0, 64'(pd_o[0]), 64'd0);
        chk("rst_rdy", 2, 64'(rdy_o[2]), 64'd1);
        chk("rst_hit", 0, 64'({hit_o[0], hid_o[0]}), 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        step_wp(8'd5, 8'd6, 8'd7, 1'b0);
        step_wp(8'd8, 8'd9, 8'd10, 1'b1);
        idle(1);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_sv", 0, 64'(sv_o[0]), 64'd1);
        chk("post_rst_id", 0, 64'(id_o[0]), 64'd0);
        idle(60);

        // Result capture: first result wins, path start clears, coincident result dropped
        step_wp(8'd1, 8'd1, 8'd1, 1'b0);
        step_wp(8'd2, 8'd2, 8'd2, 1'b1);
        @(posedge clk); #1;
        wp_val = 1'b0; res_val = 1'b1; res_line_id = 8'd5;
        @(posedge clk); #1 res_line_id = 8'd7;
        @(posedge clk); #1 res_val = 1'b0;
        @(negedge clk);
`ifdef SEG_SOURCE_HIT_EN
        chk("hit_first", 0, 64'({hit_o[0], hid_o[0]}), 64'h105);
`else
        chk("hit_off", 0, 64'({hit_o[0], hid_o[0]}), 64'h000);
`endif
        idle(10);
        step_wp(8'd3, 8'd3, 8'd3, 1'b1);
        @(posedge clk); #1;
        wp_val = 1'b0; res_val = 1'b1; res_line_id = 8'd9;
        @(posedge clk); #1 res_line_id = 8'd11;
        @(negedge clk);
        chk("hit_cleared", 0, 64'(hit_o[0]), 64'd0);
        @(posedge clk); #1 res_val = 1'b0;
        @(negedge clk);
`ifdef SEG_SOURCE_HIT_EN
        chk("hit_after_clear", 0, 64'({hit_o[0], hid_o[0]}), 64'h10b);
`else
        chk("hit_off2", 0, 64'({hit_o[0], hid_o[0]}), 64'h000);
`endif
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
